// File: rtl/mem_access_if.sv
// mem_access_if -- data-bus bundle between the memory-access stage and memory.
//   memReq     : bus request, held until memAck is sampled high
//   memWe      : write strobe (1 = store)
//   memBe      : byte enables, bit n = byte lane n (little-endian)
//   memAddrOut : word-aligned bus address (low 2 bits zero)
//   memWData   : write data, already replicated into the right lanes
//   memRData   : read data returned by memory
//   memAck     : one-cycle acknowledge from memory
// Modports: master = memory-access stage, slave = memory.
interface mem_access_if;
    logic        memReq;
    logic        memWe;
    logic [3:0]  memBe;
    logic [31:0] memAddrOut;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memAck;

    modport master (
        output memReq, memWe, memBe, memAddrOut, memWData,
        input  memRData, memAck
    );

    modport slave (
        input  memReq, memWe, memBe, memAddrOut, memWData,
        output memRData, memAck
    );
endinterface

// File: rtl/mem_access.sv
// mem_access -- pipeline memory-access stage with a request/acknowledge data bus.
// Non-memory instructions pass straight through to write-back. Loads and stores
// stall the pipeline, run one bus transfer (IDLE -> ACCESS -> DONE) and write
// back formatted load data (Lw/Ll/Lb/Lbu) or the Sc success flag. An ACCESS
// phase with no acknowledge for ACK_TIMEOUT cycles is abandoned and flagged as
// a bus error (excptype bit 10). Ll/Sc share a single link bit.
// Ports:
//   clk, rst (asynchronous, active-low)
//   op, regcData/regcWrite/regcAddr, memAddr/memData, excptype_i : execute stage
//   bus (mem_access_if.master)                                     : data bus
//   regData/regWrite/regAddr                                       : write-back
//   stall, excptype, llbit                                         : status
// Build option: define MEM_ALIGN_CHECK_EN to raise misaligned word-access
// exceptions (bit 4 for Lw/Ll, bit 5 for Sw/Sc) instead of accessing memory.
module mem_access #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [31:0]        regcData,
    input  logic               regcWrite,
    input  logic [4:0]         regcAddr,
    input  logic [31:0]        memAddr,
    input  logic [31:0]        memData,
    input  logic [31:0]        excptype_i,
    mem_access_if.master       bus,
    output logic [31:0]        regData,
    output logic               regWrite,
    output logic [4:0]         regAddr,
    output logic               stall,
    output logic [31:0]        excptype,
    output logic               llbit
);
    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SW  = 6'h2B;
    localparam logic [5:0] LL  = 6'h30;
    localparam logic [5:0] SC  = 6'h38;

    localparam logic [3:0]  TIMEOUT_CNT = 4'(ACK_TIMEOUT);
    localparam logic [31:0] BUS_ERR     = 32'h0000_0400;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_reg;
    logic        req_reg, we_reg, llbit_reg, timeout_reg;
    logic [3:0]  be_reg, cnt_reg;
    logic [31:0] addr_reg, wdata_reg, rdata_reg;

    logic        is_load, is_store, is_byte, is_mem, sc_fail, exc_any, start;
    logic [31:0] align_exc, load_data;
    logic [7:0]  byte_sel;
    logic [3:0]  cnt_next;

    assign is_load  = (op == LW) || (op == LL) || (op == LB) || (op == LBU);
    assign is_store = (op == SW) || (op == SC) || (op == SB);
    assign is_byte  = (op == LB) || (op == LBU) || (op == SB);
    assign is_mem   = is_load || is_store;
    assign sc_fail  = (op == SC) && !llbit_reg;

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        align_exc = '0;
        if (memAddr[1:0] != 2'b00) begin
            if ((op == LW) || (op == LL))
                align_exc = 32'h0000_0010;
            else if ((op == SW) || (op == SC))
                align_exc = 32'h0000_0020;
        end
    end
`else
    assign align_exc = '0;
`endif

    assign exc_any  = ((excptype_i | align_exc) != 32'd0);
    assign start    = is_mem && !exc_any && !sc_fail;
    assign cnt_next = cnt_reg + 4'd1;

    // Upstream holds op/memAddr stable through DONE, so they can still steer
    // the byte lane and result format here.
    assign byte_sel = rdata_reg[{memAddr[1:0], 3'b000} +: 8];

    always_comb begin
        case (op)
            LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     load_data = {24'd0, byte_sel};
            SC:      load_data = 32'd1;
            default: load_data = rdata_reg;
        endcase
    end

    always_comb begin
        regData  = regcData;
        regWrite = regcWrite;
        regAddr  = regcAddr;
        stall    = 1'b0;
        excptype = excptype_i | align_exc;
        if (!rst) begin
            regData  = '0;
            regWrite = 1'b0;
            excptype = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (exc_any) begin
                        regWrite = 1'b0;
                    end else if (sc_fail) begin
                        regData = '0;
                    end else if (start) begin
                        stall    = 1'b1;
                        regWrite = 1'b0;
                    end
                end
                ACCESS: begin
                    stall    = 1'b1;
                    regWrite = 1'b0;
                end
                DONE: begin
                    regWrite = 1'b0;
                    if (timeout_reg) begin
                        excptype = excptype | BUS_ERR;
                    end else if (is_load || (op == SC)) begin
                        regWrite = 1'b1;
                        regData  = load_data;
                    end
                end
                default: begin
                    regWrite = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            req_reg     <= 1'b0;
            we_reg      <= 1'b0;
            be_reg      <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            cnt_reg     <= '0;
            llbit_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timeout_reg <= 1'b0;
                    if (start) begin
                        state_reg <= ACCESS;
                        cnt_reg   <= '0;
                        req_reg   <= 1'b1;
                        we_reg    <= is_store;
                        be_reg    <= is_byte ? (4'b0001 << memAddr[1:0]) : 4'b1111;
                        addr_reg  <= {memAddr[31:2], 2'b00};
                        wdata_reg <= (op == SB) ? {4{memData[7:0]}} : memData;
                    end else if (exc_any) begin
                        llbit_reg <= 1'b0;
                    end
                end
                ACCESS: begin
                    // An ack arriving on the final allowed cycle still completes normally.
                    if (bus.memAck) begin
                        rdata_reg <= bus.memRData;
                        state_reg <= DONE;
                        req_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        be_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                        if (cnt_next == TIMEOUT_CNT) begin
                            state_reg   <= DONE;
                            timeout_reg <= 1'b1;
                            req_reg     <= 1'b0;
                            we_reg      <= 1'b0;
                            be_reg      <= '0;
                        end
                    end
                end
                DONE: begin
                    state_reg   <= IDLE;
                    timeout_reg <= 1'b0;
                    if (op == SC)
                        llbit_reg <= 1'b0;
                    else if ((op == LL) && !timeout_reg)
                        llbit_reg <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.memReq     = req_reg;
    assign bus.memWe      = we_reg;
    assign bus.memBe      = be_reg;
    assign bus.memAddrOut = addr_reg;
    assign bus.memWData   = wdata_reg;
    assign llbit          = llbit_reg;
endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
    localparam logic [5:0] NOP = 6'h00;
    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SW  = 6'h2B;
    localparam logic [5:0] LL  = 6'h30;
    localparam logic [5:0] SC  = 6'h38;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  op = NOP;
    logic [31:0] regcData = '0;
    logic        regcWrite = 1'b0;
    logic [4:0]  regcAddr = 5'd7;
    logic [31:0] memAddr = '0;
    logic [31:0] memData = '0;
    logic [31:0] excptype_i = '0;
    logic [31:0] regData, excptype;
    logic        regWrite, stall, llbit;
    logic [4:0]  regAddr;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];

    mem_access_if bus();

    mem_access #(.ACK_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .op(op),
        .regcData(regcData), .regcWrite(regcWrite), .regcAddr(regcAddr),
        .memAddr(memAddr), .memData(memData), .excptype_i(excptype_i),
        .bus(bus),
        .regData(regData), .regWrite(regWrite), .regAddr(regAddr),
        .stall(stall), .excptype(excptype), .llbit(llbit)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every write-back the stage produces must match the
    // oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && regWrite) begin
            if (sb_q.size() == 0) begin
                check_value("wb_unexpected", 32'(regWrite), 32'd0);
            end else begin
                check_value("wb_data", regData, sb_q.pop_front());
                check_value("wb_addr", 32'(regAddr), 32'd7);
            end
        end
    end

    // Called at posedge+1. waits < 0 means never acknowledge.
    task automatic txn(input string name, input logic [5:0] o, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] xi, input logic [31:0] rc,
                       input logic [31:0] rd, input int waits, input bit exp_wb,
                       input logic [31:0] exp_res, input logic [3:0] exp_be, input bit exp_we,
                       input logic [31:0] exp_wd, input int exp_stall, input int exp_req,
                       input logic [31:0] exp_exc);
        int stalls = 0;
        int reqs = 0;
        int cyc = 0;
        bit done = 0;
        op = o; memAddr = addr; memData = data; excptype_i = xi;
        regcData = rc; regcWrite = 1'b1; regcAddr = 5'd7;
        bus.memRData = rd;
        if (exp_wb) sb_q.push_back(exp_res);
        while (!done && cyc < 64) begin
            @(negedge clk);
            if (stall) stalls++;
            else done = 1;
            if (bus.memReq) begin
                check_value({name, "_be"}, 32'(bus.memBe), 32'(exp_be));
                check_value({name, "_we"}, 32'(bus.memWe), 32'(exp_we));
                check_value({name, "_aout"}, bus.memAddrOut, {addr[31:2], 2'b00});
                if (exp_we) check_value({name, "_wd"}, bus.memWData, exp_wd);
                bus.memAck = (reqs == waits);
                reqs++;
            end
            if (done) check_value({name, "_exc"}, excptype, exp_exc);
            @(posedge clk); #1;
            bus.memAck = 1'b0;
            cyc++;
        end
        check_value({name, "_finished"}, 32'(done), 32'd1);
        check_value({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        check_value({name, "_req_cycles"}, 32'(reqs), 32'(exp_req));
        op = NOP; regcWrite = 1'b0; excptype_i = '0;
        $display("txn %-10s op=%02h addr=%08h stalls=%0d reqs=%0d", name, o, addr, stalls, reqs);
    endtask

    initial begin
        bus.memAck = 1'b0;
        bus.memRData = '0;
        // Reset-time outputs with a memory op and an exception presented.
        op = LW; regcData = 32'hFFFF_FFFF; regcWrite = 1'b1; excptype_i = 32'h1;
        #3;
        check_value("rst_stall", 32'(stall), 32'd0);
        check_value("rst_regwrite", 32'(regWrite), 32'd0);
        check_value("rst_regdata", regData, 32'd0);
        check_value("rst_excptype", excptype, 32'd0);
        check_value("rst_memreq", 32'(bus.memReq), 32'd0);
        check_value("rst_llbit", 32'(llbit), 32'd0);
        op = NOP; regcWrite = 1'b0; excptype_i = '0;
        #20 rst = 1'b1;
        @(posedge clk); #1;

        txn("alu", NOP, 32'h0, 32'h0, 32'h0, 32'h1234_5678, 32'h0, -1,
            1, 32'h1234_5678, 4'h0, 0, 32'h0, 0, 0, 32'h0);
        txn("lw_wait2", LW, 32'h100, 32'h0, 32'h0, 32'hBAD0_BAD0, 32'hDEAD_BEEF, 2,
            1, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 4, 3, 32'h0);
        txn("lw_ack0", LW, 32'h104, 32'h0, 32'h0, 32'hBAD0_BAD0, 32'h0102_0304, 0,
            1, 32'h0102_0304, 4'hF, 0, 32'h0, 2, 1, 32'h0);
        txn("sb", SB, 32'h103, 32'h0000_005A, 32'h0, 32'hBAD0_BAD0, 32'h0, 0,
            0, 32'h0, 4'b1000, 1, 32'h5A5A_5A5A, 2, 1, 32'h0);
        txn("lb", LB, 32'h102, 32'h0, 32'h0, 32'hBAD0_BAD0, 32'h0080_0000, 1,
            1, 32'hFFFF_FF80, 4'b0100, 0, 32'h0, 3, 2, 32'h0);
        txn("lbu", LBU, 32'h102, 32'h0, 32'h0, 32'hBAD0_BAD0, 32'h0080_0000, 0,
            1, 32'h0000_0080, 4'b0100, 0, 32'h0, 2, 1, 32'h0);
        txn("ll", LL, 32'h200, 32'h0, 32'h0, 32'hBAD0_BAD0, 32'h1111_2222, 0,
            1, 32'h1111_2222, 4'hF, 0, 32'h0, 2, 1, 32'h0);
        check_value("ll_llbit", 32'(llbit), 32'd1);
        txn("sc_ok", SC, 32'h200, 32'h0000_CAFE, 32'h0, 32'hBAD0_BAD0, 32'h0, 0,
            1, 32'h1, 4'hF, 1, 32'h0000_CAFE, 2, 1, 32'h0);
        check_value("sc_llbit", 32'(llbit), 32'd0);
        txn("sc_fail", SC, 32'h200, 32'h0000_CAFE, 32'h0, 32'hBAD0_BAD0, 32'h0, 0,
            1, 32'h0, 4'hF, 1, 32'h0, 0, 0, 32'h0);
        txn("ll2", LL, 32'h204, 32'h0, 32'h0, 32'hBAD0_BAD0, 32'h3333_4444, 0,
            1, 32'h3333_4444, 4'hF, 0, 32'h0, 2, 1, 32'h0);
        txn("lw_excp", LW, 32'h300, 32'h0, 32'h8, 32'hBAD0_BAD0, 32'h0, 0,
            0, 32'h0, 4'hF, 0, 32'h0, 0, 0, 32'h8);
        check_value("excp_llbit", 32'(llbit), 32'd0);
        txn("timeout", LW, 32'h400, 32'h0, 32'h0, 32'hBAD0_BAD0, 32'h5555_AAAA, -1,
            0, 32'h0, 4'hF, 0, 32'h0, 16, 15, 32'h0000_0400);
        txn("ack_last", LW, 32'h404, 32'h0, 32'h0, 32'hBAD0_BAD0, 32'h7777_8888, 14,
            1, 32'h7777_8888, 4'hF, 0, 32'h0, 16, 15, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        txn("sw_misal", SW, 32'h102, 32'h0BAD_F00D, 32'h0, 32'hBAD0_BAD0, 32'h0, 0,
            0, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 0, 0, 32'h20);
`else
        txn("sw_misal", SW, 32'h102, 32'h0BAD_F00D, 32'h0, 32'hBAD0_BAD0, 32'h0, 0,
            0, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 2, 1, 32'h0);
`endif

        // Reset asserted mid-ACCESS: request must drop without a clock edge.
        op = LW; memAddr = 32'h500; regcData = 32'hFFFF_FFFF; regcWrite = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        check_value("midrst_req_before", 32'(bus.memReq), 32'd1);
        rst = 1'b0;
        #1;
        check_value("midrst_req_after", 32'(bus.memReq), 32'd0);
        check_value("midrst_stall", 32'(stall), 32'd0);
        check_value("midrst_regwrite", 32'(regWrite), 32'd0);
        check_value("midrst_regdata", regData, 32'd0);
        bus.memAck = 1'b1;
        op = NOP; regcWrite = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_value("lateack_req", 32'(bus.memReq), 32'd0);
        check_value("lateack_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        bus.memAck = 1'b0;
        @(negedge clk);
        check_value("lateack_regwrite", 32'(regWrite), 32'd0);
        check_value("lateack_stall2", 32'(stall), 32'd0);
        $display("txn %-10s reset during ACCESS", "midrst");
        @(posedge clk); #1;

        check_value("sb_left", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 15, number of ACCESS cycles without memAck before abort (4-bit counter, 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 op  input  6  opcode from execute stage; define-file constants Lw, Sw, Lb, Lbu, Sb, Ll, Sc are memory ops.
REQ-005 regcData / regcWrite / regcAddr  input  32/1/5  execute result, write enable, destination register.
REQ-006 memAddr / memData  input  32/32  effective address and store data from execute stage.
REQ-007 excptype_i  input  32  exception record from execute stage; nonzero means the instruction is excepting.
REQ-008 memReq / memWe / memBe  output  1/1/4  data-bus request, write strobe, byte enables.
REQ-009 memAddrOut / memWData  output  32/32  bus address (word-aligned, low 2 bits zero) and write data.
REQ-010 memRData / memAck  input  32/1  bus read data, one-cycle acknowledge.
REQ-011 regData / regWrite / regAddr  output  32/1/5  write-back data, enable, destination.
REQ-012 stall  output  1  holds all upstream stages while high; upstream inputs stay stable.
REQ-013 excptype  output  32  excptype_i OR-ed with bits raised here.
REQ-014 llbit  output  1  current link bit.

Function
REQ-015 FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-016 Non-memory op in IDLE: regData=regcData, regWrite=regcWrite, regAddr=regcAddr, stall=0, same cycle (combinational).
REQ-017 Memory op with excptype_i==0 in IDLE: stall=1, regWrite=0, next state ACCESS; timeout counter cleared.
REQ-018 ACCESS: memReq=1 (registered), stall=1; address/data/strobes stable until memAck sampled high.
REQ-019 memAck high in ACCESS: read data captured into 32-bit register, next state DONE; memAck in IDLE/DONE ignored.
REQ-020 DONE: stall=0, regWrite asserted for loads/Sc for exactly one cycle with captured/formatted result; next state IDLE.
REQ-021 Minimum latency with same-cycle ack: 3 cycles (IDLE, ACCESS, DONE); each extra wait cycle adds one.
REQ-022 Lw/Ll/Sw/Sc: memBe=4'b1111; Sw/Sc memWData=memData.
REQ-023 Sb: memBe=4'b0001<<memAddr[1:0]; memWData={4{memData[7:0]}} (little-endian lanes).
REQ-024 Lb sign-extends, Lbu zero-extends, the byte selected by memAddr[1:0].
REQ-025 Ll: llbit set to 1 in DONE.
REQ-026 Sc with llbit=0: no bus access, no stall; regData=0, regWrite=regcWrite in IDLE.
REQ-027 Sc with llbit=1: store performed; regData=1 in DONE; llbit cleared in DONE.
REQ-028 excptype_i nonzero: no bus access, no stall, regWrite=0, llbit cleared next edge.
REQ-029 Timeout: counter increments each ACCESS cycle without ack; reaching ACK_TIMEOUT drops memReq, enters DONE with regWrite=0 and excptype bit 10 (0x0000_0400) set for that DONE cycle.
REQ-030 Ack on the same cycle the counter hits ACK_TIMEOUT: ack wins, no bus error.

Reset
REQ-031 rst low, asynchronously: state=IDLE, memReq=0, memWe=0, memBe=0, llbit=0, counter=0, capture register=0.
REQ-032 Reset mid-ACCESS aborts the transfer; memReq falls without waiting for clk; late memAck after reset is ignored.
REQ-033 While rst low: stall=0, regWrite=0, regData=0, excptype=0.

Configuration
REQ-034 MEM_ALIGN_CHECK_EN defined: Lw/Ll with memAddr[1:0]!=0 sets excptype bit 4 (0x10), Sw/Sc sets bit 5 (0x20); treated per REQ-028 (no access, no stall).
REQ-035 MEM_ALIGN_CHECK_EN undefined: no alignment check; memAddr[1:0] ignored for word ops; bits 4/5 never raised here.

Verification
REQ-036 Lw 0x100, memRData=0xDEADBEEF, ack after 2 waits -> stall high 4 cycles, one regWrite=1 regData=0xDEADBEEF.
REQ-037 Sb addr 0x103, data 0x5A -> memBe=4'b1000, memWData=0x5A5A5A5A, memWe=1, regWrite=0.
REQ-038 Lb addr 0x102, memRData=0x00800000 -> regData=0xFFFFFF80; Lbu same -> 0x00000080.
REQ-039 Ll 0x200 then Sc 0x200 -> Sc stores, regData=1, llbit 0; second Sc -> no memReq, regData=0.
REQ-040 No ack for 15 ACCESS cycles -> memReq drops, excptype=0x400 one cycle, regWrite=0; rst low mid-ACCESS -> memReq=0 immediately.
REQ-041 With MEM_ALIGN_CHECK_EN, Sw addr 0x102 -> excptype=0x20, memReq never asserted, stall=0.
